// File: rtl/data_mem_responder.sv
// Multi-cycle word-organised data memory for the MEM stage of the pipeline.
// Holds the pipeline with memStall until each load or store has completed.
module data_mem_responder #(
    parameter int DEPTH     = 256,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        memStall,
    output logic        rdValid,
    output logic        errAlign
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] a);
        return a[IDX_W+1:2];
    endfunction

    function automatic logic is_misaligned(input logic [31:0] a);
        return (a[1:0] != 2'b00);
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   lat_in_s;
    logic               req_s;
    logic               start_s;
    logic               mem_stall_s;
    logic               op_load_r;
    logic               misalign_r;
    logic [IDX_W-1:0]   idx_r;
    logic [31:0]        wdata_r;
    logic [31:0]        mem_r [DEPTH];
    logic               cur_load_s;
    logic               cur_misalign_s;
    logic [IDX_W-1:0]   cur_idx_s;
    logic               enter_done_s;
    logic               commit_s;
    logic [31:0]        rdata_r;
    logic               rd_valid_r;
    logic               err_align_r;
    logic               unused_s;

    // Requests are masked while reset is held so memStall reads low during reset.
    assign req_s    = (memRead | memWrite) & rst;
    assign lat_in_s = memRead ? CNT_W'(READ_LAT) : CNT_W'(WRITE_LAT);
    assign unused_s = ^addr[31:IDX_W+2];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and stall decode.
    always_comb begin
        state_next_s = state_r;
        mem_stall_s  = 1'b0;
        start_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    start_s     = 1'b1;
                    mem_stall_s = 1'b1;
                    if (lat_in_s > CNT_W'(1)) begin
                        state_next_s = BUSY;
                    end else begin
                        state_next_s = DONE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                mem_stall_s = 1'b1;
                if (cnt_r <= CNT_W'(1)) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            // The request still visible here belongs to the access just finished.
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Latency counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (start_s) begin
            cnt_r <= lat_in_s - CNT_W'(1);
        end else if ((state_r == BUSY) && (cnt_r != '0)) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end
    end

    // Capture of the accepted request; later changes on the bus are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_load_r  <= 1'b0;
            misalign_r <= 1'b0;
            idx_r      <= '0;
            wdata_r    <= 32'd0;
        end else if (start_s) begin
            op_load_r  <= memRead;
            misalign_r <= is_misaligned(addr);
            idx_r      <= word_index(addr);
            wdata_r    <= wdata;
        end
    end

    // Attributes of the access about to complete; a single-cycle access is still on the bus.
    always_comb begin
        if (state_r == IDLE) begin
            cur_load_s     = memRead;
            cur_misalign_s = is_misaligned(addr);
            cur_idx_s      = word_index(addr);
        end else begin
            cur_load_s     = op_load_r;
            cur_misalign_s = misalign_r;
            cur_idx_s      = idx_r;
        end
    end

    assign enter_done_s = (state_next_s == DONE);
    assign commit_s     = (state_r == DONE) && !op_load_r && !misalign_r;

    // Storage array; stores commit at the end of their completion cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (commit_s) begin
            mem_r[idx_r] <= wdata_r;
        end
    end

    // Completion outputs, registered so they are valid throughout the DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r     <= 32'd0;
            rd_valid_r  <= 1'b0;
            err_align_r <= 1'b0;
        end else begin
            rd_valid_r  <= enter_done_s & cur_load_s;
            err_align_r <= enter_done_s & cur_misalign_s;
            if (enter_done_s && cur_load_s) begin
                rdata_r <= cur_misalign_s ? 32'd0 : mem_r[cur_idx_s];
            end
        end
    end

    assign rdata    = rdata_r;
    assign rdValid  = rd_valid_r;
    assign errAlign = err_align_r;
    assign memStall = mem_stall_s;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one default-latency instance driven from a vector
// table, plus three instances with other latencies for reset and latency checks.
module tb_data_mem_responder;

    localparam int RL [4] = '{2, 1, 3, 5};
    localparam int WL [4] = '{1, 3, 3, 3};

    logic              clk = 1'b0;
    logic [3:0]        rst_v;
    logic [3:0]        rd_v;
    logic [3:0]        wr_v;
    logic [3:0][31:0]  addr_v;
    logic [3:0][31:0]  wdata_v;
    wire  [3:0][31:0]  rdata_v;
    wire  [3:0]        stall_v;
    wire  [3:0]        rdv_v;
    wire  [3:0]        err_v;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    typedef struct {
        bit          is_load;
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } exp_t;

    exp_t sb [$];
    vec_t tbl [16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        data_mem_responder #(
            .DEPTH    (256),
            .READ_LAT (RL[g]),
            .WRITE_LAT(WL[g])
        ) dut (
            .clk      (clk),
            .rst      (rst_v[g]),
            .memRead  (rd_v[g]),
            .memWrite (wr_v[g]),
            .addr     (addr_v[g]),
            .wdata    (wdata_v[g]),
            .rdata    (rdata_v[g]),
            .memStall (stall_v[g]),
            .rdValid  (rdv_v[g]),
            .errAlign (err_v[g])
        );
    end

    always @(negedge clk) begin
        if (rdv_v[0] === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one access the cycle after the previous completion and hold it until done.
    task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rdata, input bit exp_err);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        rd_v[d] = rd; wr_v[d] = wr; addr_v[d] = a; wdata_v[d] = wd;
        e.is_load = rd;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        e.lat     = rd ? RL[d] : WL[d];
        sb.push_back(e);
        n = 0;
        @(negedge clk);
        while (stall_v[d] === 1'b1 && n < 20) begin
            check("no_early_valid", {31'd0, rdv_v[d]}, 32'd0);
            n++;
            @(negedge clk);
        end
        e = sb.pop_front();
        check("stall_len", n, e.lat);
        check("rd_valid", {31'd0, rdv_v[d]}, {31'd0, e.is_load});
        check("rdata", rdata_v[d], e.rdata);
        check("err_align", {31'd0, err_v[d]}, {31'd0, e.err});
    endtask

    task automatic idle_check(input int d, input logic [31:0] exp_rdata);
        @(posedge clk); #1;
        rd_v[d] = 1'b0; wr_v[d] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("idle_stall", {31'd0, stall_v[d]}, 32'd0);
            check("idle_valid", {31'd0, rdv_v[d]}, 32'd0);
            check("idle_rdata", rdata_v[d], exp_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h1111_1111, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 32'h0000_0013, 32'h2222_2222, 32'h1111_1111, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h3333_3333, 32'h0000_0000, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h4444_4444, 32'h3333_3333, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h3333_3333, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'h0000_0004, 32'hAAAA_5555, 32'h3333_3333, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'hAAAA_5555, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 32'h0000_07FC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000, 32'h1111_1111, 1'b0};

        rst_v = 4'b0000; rd_v = '0; wr_v = '0; addr_v = '0; wdata_v = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check("rst_stall", {31'd0, stall_v[d]}, 32'd0);
            check("rst_rdata", rdata_v[d], 32'd0);
            check("rst_valid", {31'd0, rdv_v[d]}, 32'd0);
            check("rst_err", {31'd0, err_v[d]}, 32'd0);
        end
        @(posedge clk); #1;
        rst_v = 4'b1111;

        for (int i = 0; i < 16; i++) begin
            access(0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].exp_rdata, tbl[i].exp_err);
        end
        idle_check(0, 32'h1111_1111);

        p0 = pulse_cnt;
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h1111_1111, 1'b0);
        access(0, 1'b1, 1'b0, 32'h4, 32'h0, 32'hAAAA_5555, 1'b0);
        access(0, 1'b1, 1'b0, 32'h8, 32'h0, 32'h0000_0000, 1'b0);
        idle_check(0, 32'h0000_0000);
        check("b2b_pulses", pulse_cnt - p0, 32'd3);

        @(posedge clk); #1;
        rd_v[2] = 1'b0; wr_v[2] = 1'b1; addr_v[2] = 32'h30; wdata_v[2] = 32'h5A5A_5A5A;
        @(negedge clk);
        check("abort_stall_idle", {31'd0, stall_v[2]}, 32'd1);
        @(negedge clk);
        check("abort_stall_busy", {31'd0, stall_v[2]}, 32'd1);
        #1 rst_v[2] = 1'b0;
        #1;
        check("abort_stall", {31'd0, stall_v[2]}, 32'd0);
        check("abort_valid", {31'd0, rdv_v[2]}, 32'd0);
        check("abort_err", {31'd0, err_v[2]}, 32'd0);
        @(posedge clk); #1;
        wr_v[2] = 1'b0;
        rst_v[2] = 1'b1;
        access(2, 1'b1, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0);
        idle_check(2, 32'h0);

        for (int d = 1; d < 4; d++) begin
            access(d, 1'b0, 1'b1, 32'h40, 32'hC0DE_0000 + 32'(d), 32'h0, 1'b0);
            access(d, 1'b1, 1'b0, 32'h40, 32'h0, 32'hC0DE_0000 + 32'(d), 1'b0);
            access(d, 1'b1, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1);
            idle_check(d, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
